// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
//   channel_state_t    : per-request FSM state (IDLE / WAIT / RESP)
//   LATENCY_COUNT_BITS : width of the per-FSM latency down-counter
//   latency_init_count : counter start value for a given response latency
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } channel_state_t;

    localparam int LATENCY_COUNT_BITS = 4;

    // The request edge counts as the first latency cycle and the RESP-entry
    // edge as the last, so WAIT spends LATENCY-2 extra edges counting down.
    function automatic logic [LATENCY_COUNT_BITS-1:0] latency_init_count(input int latency);
        if (latency >= 2) begin
            latency_init_count = LATENCY_COUNT_BITS'(latency - 2);
        end else begin
            latency_init_count = {LATENCY_COUNT_BITS{1'b0}};
        end
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Bus bundle between the GPU memory controller (master) and the memory
// responder (slave), plus the backdoor load/peek port.
//   mem_read_*  : per-channel read request address / ready / data
//   mem_write_* : per-channel write request address / data / ready
//   load_*      : backdoor write strobe, address, data
//   peek_*      : backdoor combinational read address / data
interface data_mem_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4
);
    logic [CHANNELS-1:0]           mem_read_valid;
    logic [CHANNELS*ADDR_BITS-1:0] mem_read_address;
    logic [CHANNELS-1:0]           mem_read_ready;
    logic [CHANNELS*DATA_BITS-1:0] mem_read_data;
    logic [CHANNELS-1:0]           mem_write_valid;
    logic [CHANNELS*ADDR_BITS-1:0] mem_write_address;
    logic [CHANNELS*DATA_BITS-1:0] mem_write_data;
    logic [CHANNELS-1:0]           mem_write_ready;
    logic                          load_enable;
    logic [ADDR_BITS-1:0]          load_address;
    logic [DATA_BITS-1:0]          load_data;
    logic [ADDR_BITS-1:0]          peek_address;
    logic [DATA_BITS-1:0]          peek_data;

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready,
        input  load_enable, load_address, load_data, peek_address,
        output peek_data
    );

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready,
        output load_enable, load_address, load_data, peek_address,
        input  peek_data
    );
endinterface

// File: rtl/data_mem_responder_channel_fsm.sv
// One request FSM (read or write) with its latency counter and payload latch.
//   clk, reset   : clock, asynchronous active-low reset
//   valid        : request strobe from the controller
//   payload      : request contents (address, or address+data)
//   ready        : registered response/acknowledge
//   fire         : high during the cycle whose closing edge enters RESP
//   fire_payload : payload to act on at that edge
module mem_channel_fsm
    import data_mem_responder_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [PAYLOAD_BITS-1:0] payload,
    output logic                    ready,
    output logic                    fire,
    output logic [PAYLOAD_BITS-1:0] fire_payload
);
    localparam logic [LATENCY_COUNT_BITS-1:0] INIT_COUNT = latency_init_count(LATENCY);

    channel_state_t                state_q, state_d;
    logic [LATENCY_COUNT_BITS-1:0] count_q, count_d;
    logic [PAYLOAD_BITS-1:0]       payload_q, payload_d;
    logic                          ready_q, ready_d;

    // Next-state, counter, latch and fire decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        payload_d    = payload_q;
        fire         = 1'b0;
        fire_payload = payload_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    payload_d = payload;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: act on the live payload right away.
                        state_d      = RESP;
                        fire         = 1'b1;
                        fire_payload = payload;
                    end else begin
                        state_d = WAIT;
                        count_d = INIT_COUNT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!valid) begin
                    // Request withdrawn: abandon it without responding.
                    state_d = IDLE;
                end else if (count_q == {LATENCY_COUNT_BITS{1'b0}}) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end else begin
                    count_d = count_q - {{(LATENCY_COUNT_BITS-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == RESP);
    end

    // State, counter, payload latch and ready registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= {LATENCY_COUNT_BITS{1'b0}};
            payload_q <= {PAYLOAD_BITS{1'b0}};
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            payload_q <= payload_d;
            ready_q   <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-channel fixed-latency memory responder with a backdoor load/peek port.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave side of data_mem_responder_if (read/write channels,
//                backdoor load, combinational peek)
// Owns the word array, the write-commit priority and the read data registers.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]                mem_q [DEPTH];
    logic [CHANNELS-1:0]                 rd_ready_s, rd_fire_s;
    logic [CHANNELS-1:0]                 wr_ready_s, wr_fire_s;
    logic [CHANNELS-1:0][ADDR_BITS-1:0]  rd_addr_s;
    logic [CHANNELS-1:0][ADDR_BITS-1:0]  wr_addr_s;
    logic [CHANNELS-1:0][DATA_BITS-1:0]  wr_data_s;
    logic [CHANNELS-1:0][DATA_BITS-1:0]  rdata_q, rdata_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ADDR_BITS+DATA_BITS-1:0] wr_payload_s;

        mem_channel_fsm #(
            .PAYLOAD_BITS (ADDR_BITS),
            .LATENCY      (LATENCY)
        ) u_rd (
            .clk          (clk),
            .reset        (reset),
            .valid        (bus.mem_read_valid[c]),
            .payload      (bus.mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
            .ready        (rd_ready_s[c]),
            .fire         (rd_fire_s[c]),
            .fire_payload (rd_addr_s[c])
        );

        mem_channel_fsm #(
            .PAYLOAD_BITS (ADDR_BITS + DATA_BITS),
            .LATENCY      (LATENCY)
        ) u_wr (
            .clk          (clk),
            .reset        (reset),
            .valid        (bus.mem_write_valid[c]),
            .payload      ({bus.mem_write_address[c*ADDR_BITS +: ADDR_BITS],
                            bus.mem_write_data[c*DATA_BITS +: DATA_BITS]}),
            .ready        (wr_ready_s[c]),
            .fire         (wr_fire_s[c]),
            .fire_payload (wr_payload_s)
        );

        assign wr_addr_s[c] = wr_payload_s[ADDR_BITS+DATA_BITS-1:DATA_BITS];
        assign wr_data_s[c] = wr_payload_s[DATA_BITS-1:0];
    end

    // Read data: sample the array on fire, hold while in RESP, else return to zero.
    // Sampling mem_q before this edge's writes land gives read-old-value semantics.
    always_comb begin
        rdata_d = {(CHANNELS*DATA_BITS){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_fire_s[c]) begin
                rdata_d[c] = mem_q[rd_addr_s[c]];
            end else if (rd_ready_s[c] && bus.mem_read_valid[c]) begin
                rdata_d[c] = rdata_q[c];
            end else begin
                rdata_d[c] = {DATA_BITS{1'b0}};
            end
        end
    end

    // Read data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= {(CHANNELS*DATA_BITS){1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Array update: later non-blocking writes win, so the loop runs from the
    // highest channel down and the backdoor load is applied last.
    always_ff @(posedge clk) begin
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (wr_fire_s[c]) begin
                mem_q[wr_addr_s[c]] <= wr_data_s[c];
            end
        end
        if (bus.load_enable) begin
            mem_q[bus.load_address] <= bus.load_data;
        end
    end

    assign bus.mem_read_ready  = rd_ready_s;
    assign bus.mem_write_ready = wr_ready_s;
    assign bus.mem_read_data   = rdata_q;
    assign bus.peek_data       = mem_q[bus.peek_address];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at latency 2 (main
// traffic) and one at latency 4 (withdrawn-request case).
module tb_data_mem_responder;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    data_mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4)) bus_a ();
    data_mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4)) bus_b ();

    data_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    data_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_v, b_v, exp_v, addr_v, data_v;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus_a.mem_read_valid = 4'h0;  bus_a.mem_read_address  = 32'h0;
        bus_a.mem_write_valid = 4'h0; bus_a.mem_write_address = 32'h0;
        bus_a.mem_write_data = 32'h0; bus_a.load_enable = 1'b0;
        bus_a.load_address = 8'h0;    bus_a.load_data = 8'h0; bus_a.peek_address = 8'h0;
        bus_b.mem_read_valid = 4'h0;  bus_b.mem_read_address  = 32'h0;
        bus_b.mem_write_valid = 4'h0; bus_b.mem_write_address = 32'h0;
        bus_b.mem_write_data = 32'h0; bus_b.load_enable = 1'b0;
        bus_b.load_address = 8'h0;    bus_b.load_data = 8'h0; bus_b.peek_address = 8'h0;

        // Reset state
        step(2);
        check("rst_rd_ready", {28'h0, bus_a.mem_read_ready}, 32'h0);
        check("rst_wr_ready", {28'h0, bus_a.mem_write_ready}, 32'h0);
        check("rst_rd_data", bus_a.mem_read_data, 32'h0);
        check("rst_b_rd_ready", {28'h0, bus_b.mem_read_ready}, 32'h0);
        reset = 1'b1;

        // Preload: [0..15] = 0..7,0..7 ; [20] = 0x11 ; B[9] = 0x42
        for (int i = 0; i < 16; i++) begin
            bus_a.load_enable  = 1'b1;
            bus_a.load_address = 8'(i);
            bus_a.load_data    = 8'(i % 8);
            step(1);
        end
        bus_a.load_address = 8'd20; bus_a.load_data = 8'h11;
        bus_b.load_enable = 1'b1; bus_b.load_address = 8'd9; bus_b.load_data = 8'h42;
        step(1);
        bus_a.load_enable = 1'b0; bus_b.load_enable = 1'b0;
        bus_a.peek_address = 8'd13; #1;
        check("preload_peek13", {24'h0, bus_a.peek_data}, 32'h5);

        // Ch0 read addr 5
        bus_a.mem_read_valid = 4'b0001; bus_a.mem_read_address = 32'h0000_0005;
        step(1);
        check("rd5_wait_ready", {28'h0, bus_a.mem_read_ready}, 32'h0);
        step(1);
        check("rd5_ready", {28'h0, bus_a.mem_read_ready}, 32'h1);
        check("rd5_data", bus_a.mem_read_data, 32'h0000_0005);
        bus_a.mem_read_valid = 4'b0000;
        step(1);
        check("rd5_fall_ready", {28'h0, bus_a.mem_read_ready}, 32'h0);
        check("rd5_fall_data", bus_a.mem_read_data, 32'h0);

        // Ch1 write addr 16 = 8, then hold with different data
        bus_a.peek_address = 8'd16;
        bus_a.mem_write_valid = 4'b0010;
        bus_a.mem_write_address = 32'h0000_1000; bus_a.mem_write_data = 32'h0000_0800;
        step(1);
        check("wr16_wait_ready", {28'h0, bus_a.mem_write_ready}, 32'h0);
        step(1);
        check("wr16_ready", {28'h0, bus_a.mem_write_ready}, 32'h2);
        check("wr16_peek", {24'h0, bus_a.peek_data}, 32'h8);
        bus_a.mem_write_data = 32'h0000_3300;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("wr16_hold_ready", {28'h0, bus_a.mem_write_ready}, 32'h2);
            check("wr16_hold_peek", {24'h0, bus_a.peek_data}, 32'h8);
        end
        bus_a.mem_write_valid = 4'b0000;
        step(1);
        check("wr16_fall_ready", {28'h0, bus_a.mem_write_ready}, 32'h0);

        // All channels read addr 3
        bus_a.mem_read_valid = 4'hF; bus_a.mem_read_address = 32'h0303_0303;
        step(2);
        check("rd3_all_ready", {28'h0, bus_a.mem_read_ready}, 32'hF);
        check("rd3_all_data", bus_a.mem_read_data, 32'h0303_0303);
        bus_a.mem_read_valid = 4'h0;
        step(1);
        check("rd3_all_fall", bus_a.mem_read_data, 32'h0);

        // Ch0/ch2 write addr 20 (0xAA/0x55), ch3 reads 20 on the commit edge
        bus_a.peek_address = 8'd20;
        bus_a.mem_write_valid = 4'b0101;
        bus_a.mem_write_address = 32'h0014_0014; bus_a.mem_write_data = 32'h0055_00AA;
        bus_a.mem_read_valid = 4'b1000; bus_a.mem_read_address = 32'h1400_0000;
        step(2);
        check("wr20_ready", {28'h0, bus_a.mem_write_ready}, 32'h5);
        check("rd20_ready", {28'h0, bus_a.mem_read_ready}, 32'h8);
        check("rd20_old_data", bus_a.mem_read_data, 32'h1100_0000);
        check("wr20_prio_peek", {24'h0, bus_a.peek_data}, 32'hAA);
        bus_a.mem_write_valid = 4'h0; bus_a.mem_read_valid = 4'h0;
        step(1);

        // Backdoor load beats a channel write to the same address
        bus_a.mem_write_valid = 4'b0010;
        bus_a.mem_write_address = 32'h0000_1500; bus_a.mem_write_data = 32'h0000_9900;
        step(1);
        bus_a.load_enable = 1'b1; bus_a.load_address = 8'd21; bus_a.load_data = 8'h77;
        step(1);
        bus_a.load_enable = 1'b0;
        bus_a.peek_address = 8'd21; #1;
        check("ld21_wr_ready", {28'h0, bus_a.mem_write_ready}, 32'h2);
        check("ld21_override", {24'h0, bus_a.peek_data}, 32'h77);
        bus_a.mem_write_valid = 4'h0;
        step(1);

        // Latency 4: withdrawn request gives no pulse, next one completes
        bus_b.mem_read_valid = 4'b0001; bus_b.mem_read_address = 32'h0000_0009;
        step(1);
        bus_b.mem_read_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("abort_no_ready", {28'h0, bus_b.mem_read_ready}, 32'h0);
        end
        bus_b.mem_read_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("lat4_wait_ready", {28'h0, bus_b.mem_read_ready}, 32'h0);
        end
        step(1);
        check("lat4_ready", {28'h0, bus_b.mem_read_ready}, 32'h1);
        check("lat4_data", bus_b.mem_read_data, 32'h0000_0042);
        bus_b.mem_read_valid = 4'b0000;
        step(1);

        // Async reset while ch2 is in RESP
        bus_a.mem_read_valid = 4'b0100; bus_a.mem_read_address = 32'h0006_0000;
        step(2);
        check("rd6_ready", {28'h0, bus_a.mem_read_ready}, 32'h4);
        check("rd6_data", bus_a.mem_read_data, 32'h0006_0000);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", {28'h0, bus_a.mem_read_ready}, 32'h0);
        check("async_rst_data", bus_a.mem_read_data, 32'h0);
        bus_a.mem_read_valid = 4'b0000;
        step(1);
        reset = 1'b1;
        bus_a.peek_address = 8'd5;  #1;
        check("post_rst_peek5", {24'h0, bus_a.peek_data}, 32'h5);
        bus_a.peek_address = 8'd20; #1;
        check("post_rst_peek20", {24'h0, bus_a.peek_data}, 32'hAA);
        bus_a.peek_address = 8'd16; #1;
        check("post_rst_peek16", {24'h0, bus_a.peek_data}, 32'h8);

        // Matadd: C[16+i] = A[i] + B[8+i], 8 threads over 4 channels
        for (int r = 0; r < 2; r++) begin
            addr_v = 32'h0; exp_v = 32'h0;
            for (int c = 0; c < 4; c++) begin
                addr_v[c*8 +: 8] = 8'(4*r + c);
                exp_v[c*8 +: 8]  = 8'(4*r + c);
            end
            bus_a.mem_read_valid = 4'hF; bus_a.mem_read_address = addr_v;
            step(2);
            check("mat_rd_a", bus_a.mem_read_data, exp_v);
            a_v = bus_a.mem_read_data;
            bus_a.mem_read_valid = 4'h0;
            step(1);
            for (int c = 0; c < 4; c++) addr_v[c*8 +: 8] = 8'(8 + 4*r + c);
            bus_a.mem_read_valid = 4'hF; bus_a.mem_read_address = addr_v;
            step(2);
            check("mat_rd_b", bus_a.mem_read_data, exp_v);
            b_v = bus_a.mem_read_data;
            bus_a.mem_read_valid = 4'h0;
            step(1);
            for (int c = 0; c < 4; c++) begin
                addr_v[c*8 +: 8] = 8'(16 + 4*r + c);
                data_v[c*8 +: 8] = a_v[c*8 +: 8] + b_v[c*8 +: 8];
            end
            bus_a.mem_write_valid = 4'hF;
            bus_a.mem_write_address = addr_v; bus_a.mem_write_data = data_v;
            step(2);
            check("mat_wr_ready", {28'h0, bus_a.mem_write_ready}, 32'hF);
            bus_a.mem_write_valid = 4'h0;
            step(1);
        end
        for (int i = 0; i < 8; i++) begin
            bus_a.peek_address = 8'(16 + i); #1;
            check("mat_result", {24'h0, bus_a.peek_data}, 32'(2 * i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Synthesizable multi-channel memory responder: the memory-side end of the GPU's valid/ready data-memory interface.
- Accepts per-channel read and write requests from the GPU memory controller and answers after a programmable fixed latency.
- Holds a shared word array, plus a backdoor load/peek port so benches and FPGA top-levels can preload kernels' data and check results without a software memory model.

Parameters:
ADDR_BITS, 8, word address width; array depth 2**ADDR_BITS
DATA_BITS, 8, word width
CHANNELS, 4, number of independent read+write channel pairs
LATENCY, 2, cycles from sampled request to ready; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read_valid  in  CHANNELS  per-channel read request
mem_read_address  in  CHANNELS*ADDR_BITS  per-channel read address
mem_read_ready  out  CHANNELS  per-channel read response valid
mem_read_data  out  CHANNELS*DATA_BITS  per-channel read data
mem_write_valid  in  CHANNELS  per-channel write request
mem_write_address  in  CHANNELS*ADDR_BITS  per-channel write address
mem_write_data  in  CHANNELS*DATA_BITS  per-channel write data
mem_write_ready  out  CHANNELS  per-channel write acknowledge
load_enable  in  1  backdoor write strobe
load_address  in  ADDR_BITS  backdoor address
load_data  in  DATA_BITS  backdoor data
peek_address  in  ADDR_BITS  backdoor combinational read address
peek_data  out  DATA_BITS  array[peek_address], combinational

Behaviour:
- Reset (reset=0, async): all ready outputs 0, all mem_read_data 0, every FSM in IDLE. Array contents are not cleared.
- Each channel has an independent read FSM and write FSM (2*CHANNELS in total). Each FSM has states IDLE, WAIT, RESP, with a 4-bit down-counter.
- IDLE: at an edge where valid=1, latch the address (and data, for writes).
  - If LATENCY=1, go directly to RESP at that edge.
  - Otherwise go to WAIT with count=LATENCY-2.
- WAIT: decrement each edge. At count=0 with valid=1, go to RESP.
  - If valid is sampled 0 in WAIT, abort to IDLE: no ready pulse, no write committed.
  - Address/data changes during WAIT are ignored; latched values are used.
- Entering RESP, registered ready rises at edge E0+LATENCY-1, where E0 is the edge that sampled the request.
  - Read: mem_read_data is loaded from the array at that same edge.
  - Write: the latched data is committed to the array at that same edge.
- RESP: ready and data held stable while valid=1. At the first edge sampling valid=0, ready falls, read data returns to 0, state goes to IDLE.
  - A new request therefore needs at least one cycle of valid low between transactions.
- Same-edge conflicts:
  - Read sample and write commit to the same address: read returns the old value.
  - Multiple write commits to the same address: the lowest channel index wins.
  - load_enable overrides all channel writes to the same address.
- Reads from different channels to the same address are all served in parallel; there is no arbitration stall.
- Address width arithmetic is unsigned. There is no out-of-range case because depth is 2**ADDR_BITS.

Decomposition:
- Package data_mem_responder_pkg: channel_state_t enum {IDLE, WAIT, RESP}, plus a LATENCY_COUNT_BITS=4 constant.
- Sub-module mem_channel_fsm: one request FSM with its counter and latches, parameterized on payload width. Instantiated CHANNELS times for reads (payload=ADDR_BITS) and CHANNELS times for writes (payload=ADDR_BITS+DATA_BITS).
- The top level owns the array, the commit priority logic and the backdoor port.

Test Plan:
- Preload via load port: array[0..15]=0,1,..7,0,1,..7. Ch0 read addr 5, LATENCY=2 → mem_read_ready[0] rises 2 edges after request sample, data=5; falls 1 edge after valid drops.
- Ch1 write addr 16 data 8 → write_ready[1] after 2 edges; peek_data at 16 = 8. Ch1 then holds valid 3 more cycles → ready stays 1 with no second commit.
- All 4 channels read addr 3 simultaneously → all four readies rise on the same edge, each with data=3.
- Ch0 and ch2 write addr 20 with 0xAA and 0x55 in the same cycle → array[20]=0xAA. Ch3 reading 20 with a same-edge sample gets the old value.
- Ch0 read valid dropped after 1 cycle in WAIT (LATENCY=4) → no ready pulse, FSM back in IDLE; a following request completes normally.
- Reset asserted while ch2 is in RESP → ready and data go 0 immediately (async). Preloaded array contents are intact after reset release; a matadd-style 8-thread run writes 16+i = 2i for i=0..7.
